// File: rtl/cache_controller.sv
// MEM-stage sequencer for a write-through, no-write-allocate 2-way data cache and its SRAM controller.
// Optional hit/miss statistics counters are enabled with `define CACHE_CTRL_STATS_EN.
module cache_controller #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int CACHE_ADDR_W = 17,
  parameter int BASE_ADDR    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_r_en,
  input  logic                    mem_w_en,
  input  logic [ADDR_W-1:0]       mem_address,
  input  logic [DATA_W-1:0]       mem_wdata,
  output logic [DATA_W-1:0]       mem_rdata,
  output logic                    ready,
  output logic [CACHE_ADDR_W-1:0] cache_address,
  output logic [2*DATA_W-1:0]     cache_write_data,
  output logic                    cache_read_en,
  output logic                    cache_write_en,
  output logic                    cache_invalidate,
  input  logic [DATA_W-1:0]       cache_read_data,
  input  logic                    cache_hit,
`ifdef CACHE_CTRL_STATS_EN
  output logic [15:0]             hit_count,
  output logic [15:0]             miss_count,
`endif
  output logic [ADDR_W-1:0]       sram_address,
  output logic [DATA_W-1:0]       sram_wdata,
  output logic                    sram_r_en,
  output logic                    sram_w_en,
  input  logic [2*DATA_W-1:0]     sram_rdata,
  input  logic                    sram_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

  // BASE_ADDR is a multiple of 8, so subtracting it on word bits alone is exact and keeps line pairs intact.
  localparam logic [CACHE_ADDR_W-1:0] BASE_WORD_C = CACHE_ADDR_W'(BASE_ADDR >> 2);

  state_t              state_r;
  state_t              next_state_s;
  logic                store_path_s;
  logic [DATA_W-1:0]   fill_word_s;

  assign cache_address    = mem_address[CACHE_ADDR_W+1:2] - BASE_WORD_C;
  assign cache_write_data = sram_rdata;
  assign sram_wdata       = mem_wdata;
  assign store_path_s     = (state_r == WR_THRU) || ((state_r == IDLE) && mem_w_en);
  assign sram_address     = store_path_s ? mem_address : {mem_address[ADDR_W-1:3], 3'b000};
  assign fill_word_s      = mem_address[2] ? sram_rdata[2*DATA_W-1:DATA_W] : sram_rdata[DATA_W-1:0];

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode; outputs are forced idle while reset is asserted.
  always_comb begin
    next_state_s     = state_r;
    ready            = 1'b1;
    mem_rdata        = '0;
    cache_read_en    = 1'b0;
    cache_write_en   = 1'b0;
    cache_invalidate = 1'b0;
    sram_r_en        = 1'b0;
    sram_w_en        = 1'b0;
    if (!rst) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (mem_w_en) begin
            cache_invalidate = 1'b1;
            ready            = 1'b0;
            next_state_s     = WR_THRU;
          end else if (mem_r_en) begin
            cache_read_en = 1'b1;
            if (cache_hit) begin
              mem_rdata = cache_read_data;
              ready     = 1'b1;
            end else begin
              ready        = 1'b0;
              next_state_s = RD_MISS;
            end
          end else begin
            ready = 1'b1;
          end
        end
        RD_MISS: begin
          sram_r_en = 1'b1;
          if (sram_ready) begin
            cache_write_en = 1'b1;
            mem_rdata      = fill_word_s;
            ready          = 1'b1;
            next_state_s   = IDLE;
          end else begin
            ready = 1'b0;
          end
        end
        WR_THRU: begin
          sram_w_en = 1'b1;
          if (sram_ready) begin
            ready        = 1'b1;
            next_state_s = IDLE;
          end else begin
            ready = 1'b0;
          end
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic hit_evt_s;
  logic miss_evt_s;

  assign hit_evt_s  = (state_r == IDLE) && !mem_w_en && mem_r_en && cache_hit;
  assign miss_evt_s = (state_r == IDLE) && !mem_w_en && mem_r_en && !cache_hit;

  // Saturating hit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count <= 16'd0;
    end else if (hit_evt_s && (hit_count != 16'hFFFF)) begin
      hit_count <= hit_count + 16'd1;
    end else begin
      hit_count <= hit_count;
    end
  end

  // Saturating miss counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_count <= 16'd0;
    end else if (miss_evt_s && (miss_count != 16'hFFFF)) begin
      miss_count <= miss_count + 16'd1;
    end else begin
      miss_count <= miss_count;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Randomized self-checking bench for cache_controller; the bench plays both the cache and the SRAM
// and predicts every output from a transaction-level model of the load/store protocol.
module tb_cache_controller;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CAW    = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_r_en, mem_w_en;
  logic [31:0]       mem_address, mem_wdata, mem_rdata;
  logic              ready;
  logic [CAW-1:0]    cache_address;
  logic [63:0]       cache_write_data;
  logic              cache_read_en, cache_write_en, cache_invalidate;
  logic [31:0]       cache_read_data;
  logic              cache_hit;
  logic [31:0]       sram_address, sram_wdata;
  logic              sram_r_en, sram_w_en;
  logic [63:0]       sram_rdata;
  logic              sram_ready;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0]       hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CACHE_ADDR_W(CAW), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ready(ready),
    .cache_address(cache_address), .cache_write_data(cache_write_data),
    .cache_read_en(cache_read_en), .cache_write_en(cache_write_en), .cache_invalidate(cache_invalidate),
    .cache_read_data(cache_read_data), .cache_hit(cache_hit),
`ifdef CACHE_CTRL_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  int checks = 0;
  int errors = 0;

  logic           exp_ready, exp_cre, exp_cwe, exp_cinv, exp_sre, exp_swe;
  logic [31:0]    exp_rdata, exp_saddr;
  logic [CAW-1:0] exp_caddr;
  logic           chk_on = 1'b0;
  logic           chk_rdata, chk_saddr;
  logic [31:0]    last_rdata;
  logic [CAW-1:0] last_caddr;

  logic [63:0] smem  [int];
  logic [63:0] cline [int];
  int          mdl_hits = 0, mdl_misses = 0;
  bit          pend_hit = 1'b0, pend_miss = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CAW-1:0] caddr(input logic [31:0] a);
    logic [31:0] d;
    d = a - 32'd1024;
    return d[CAW+1:2];
  endfunction

  function automatic int lkey(input logic [31:0] a);
    logic [CAW-1:0] c;
    c = caddr(a);
    return int'(c[CAW-1:1]);
  endfunction

  function automatic int skey(input logic [31:0] a);
    return int'(a[31:3]);
  endfunction

  function automatic logic [63:0] sram_line(input logic [31:0] a);
    if (!smem.exists(skey(a))) smem[skey(a)] = {$urandom, $urandom};
    return smem[skey(a)];
  endfunction

  // Compare every DUT output against the model's expectation for this cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready", ready, exp_ready);
      chk("cache_read_en", cache_read_en, exp_cre);
      chk("cache_write_en", cache_write_en, exp_cwe);
      chk("cache_invalidate", cache_invalidate, exp_cinv);
      chk("sram_r_en", sram_r_en, exp_sre);
      chk("sram_w_en", sram_w_en, exp_swe);
      chk("cache_address", cache_address, exp_caddr);
      chk("sram_wdata", sram_wdata, mem_wdata);
      chk("cache_write_data", cache_write_data, sram_rdata);
      if (chk_saddr) chk("sram_address", sram_address, exp_saddr);
      if (chk_rdata) begin
        chk("mem_rdata", mem_rdata, exp_rdata);
        last_rdata = mem_rdata;
      end
      last_caddr = cache_address;
`ifdef CACHE_CTRL_STATS_EN
      chk("hit_count", hit_count, 64'(mdl_hits));
      chk("miss_count", miss_count, 64'(mdl_misses));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) begin
      mdl_hits = 0;
      mdl_misses = 0;
    end else begin
      if (pend_hit && mdl_hits < 65535) mdl_hits++;
      if (pend_miss && mdl_misses < 65535) mdl_misses++;
    end
    pend_hit = 1'b0;
    pend_miss = 1'b0;
  endtask

  task automatic idle_exp();
    exp_ready = 1'b1; exp_cre = 1'b0; exp_cwe = 1'b0; exp_cinv = 1'b0;
    exp_sre = 1'b0; exp_swe = 1'b0; chk_rdata = 1'b0; chk_saddr = 1'b0;
    exp_rdata = 32'd0; exp_saddr = 32'd0;
  endtask

  task automatic idle_cycle();
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    mem_address = $urandom & 32'hFFFF_FFFC; mem_wdata = $urandom;
    cache_hit = 1'($urandom_range(0, 1)); cache_read_data = $urandom;
    sram_ready = 1'($urandom_range(0, 1)); sram_rdata = {$urandom, $urandom};
    idle_exp();
    exp_caddr = caddr(mem_address);
    tick();
  endtask

  task automatic do_load(input logic [31:0] addr, input int lat, input bit drop);
    logic [63:0] line;
    int k;
    k = lkey(addr);
    mem_address = addr; mem_r_en = 1'b1; mem_w_en = 1'b0; mem_wdata = $urandom;
    sram_ready = 1'($urandom_range(0, 1)); sram_rdata = {$urandom, $urandom};
    idle_exp();
    exp_caddr = caddr(addr);
    exp_cre = 1'b1;
    if (cline.exists(k)) begin
      line = cline[k];
      cache_hit = 1'b1;
      cache_read_data = addr[2] ? line[63:32] : line[31:0];
      exp_rdata = addr[2] ? line[63:32] : line[31:0];
      chk_rdata = 1'b1;
      pend_hit = 1'b1;
      tick();
    end else begin
      cache_hit = 1'b0;
      cache_read_data = $urandom;
      exp_ready = 1'b0;
      pend_miss = 1'b1;
      tick();
      line = sram_line(addr);
      for (int j = 0; j <= lat; j++) begin
        idle_exp();
        exp_ready = (j == lat);
        exp_sre = 1'b1;
        exp_saddr = {addr[31:3], 3'b000};
        chk_saddr = 1'b1;
        cache_hit = 1'($urandom_range(0, 1));
        cache_read_data = $urandom;
        if (drop && j > 0) mem_r_en = 1'b0;
        if (j == lat) begin
          sram_ready = 1'b1;
          sram_rdata = line;
          exp_cwe = 1'b1;
          if (!drop) begin
            chk_rdata = 1'b1;
            exp_rdata = addr[2] ? line[63:32] : line[31:0];
          end
        end else begin
          sram_ready = 1'b0;
          sram_rdata = {$urandom, $urandom};
        end
        tick();
      end
      cline[k] = line;
    end
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input int lat, input bit both);
    logic [63:0] line;
    mem_address = addr; mem_w_en = 1'b1; mem_r_en = both; mem_wdata = data;
    cache_hit = 1'($urandom_range(0, 1)); cache_read_data = $urandom;
    sram_ready = 1'($urandom_range(0, 1)); sram_rdata = {$urandom, $urandom};
    idle_exp();
    exp_caddr = caddr(addr);
    exp_cinv = 1'b1; exp_ready = 1'b0;
    exp_saddr = addr; chk_saddr = 1'b1;
    tick();
    cline.delete(lkey(addr));
    line = sram_line(addr);
    if (addr[2]) line[63:32] = data;
    else line[31:0] = data;
    smem[skey(addr)] = line;
    for (int j = 0; j <= lat; j++) begin
      idle_exp();
      exp_ready = (j == lat);
      exp_swe = 1'b1;
      exp_saddr = addr; chk_saddr = 1'b1;
      cache_hit = 1'($urandom_range(0, 1)); cache_read_data = $urandom;
      sram_ready = (j == lat);
      sram_rdata = {$urandom, $urandom};
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sel, lat;
    logic [31:0] a;
    rst = 1'b0;
    mem_r_en = 1'b0; mem_w_en = 1'b0; mem_address = 32'd0; mem_wdata = 32'd0;
    cache_read_data = 32'd0; cache_hit = 1'b0; sram_rdata = 64'd0; sram_ready = 1'b0;
    idle_exp();
    exp_caddr = caddr(32'd0);
    chk_on = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    idle_cycle();
    idle_cycle();

    // Cold load miss, then a hit on the other word of the filled line.
    smem[skey(32'h408)] = 64'hBBBB_0002_AAAA_0001;
    do_load(32'h0000_0408, 5, 1'b0);
    chk("lit_miss_rdata", last_rdata, 64'h0000_0000_AAAA_0001);
    chk("lit_caddr", last_caddr, 64'd2);
    do_load(32'h0000_040C, 0, 1'b0);
    chk("lit_hit_rdata", last_rdata, 64'h0000_0000_BBBB_0002);
`ifdef CACHE_CTRL_STATS_EN
    chk("lit_hit_count", hit_count, 64'd1);
    chk("lit_miss_count", miss_count, 64'd1);
`endif
    idle_cycle();

    // Store invalidates; the following load misses and sees the new word.
    do_store(32'h0000_0408, 32'h0000_1234, 3, 1'b0);
    do_load(32'h0000_0408, 2, 1'b0);
    chk("lit_after_store", last_rdata, 64'h0000_0000_0000_1234);

    // Simultaneous load and store takes the store path.
    do_store(32'h0000_0500, 32'hCAFE_F00D, 2, 1'b1);

    // Reset in the middle of a miss.
    cline.delete(lkey(32'h0000_0600));
    mem_address = 32'h0000_0600; mem_r_en = 1'b1; mem_w_en = 1'b0;
    cache_hit = 1'b0; sram_ready = 1'b0;
    idle_exp(); exp_caddr = caddr(32'h0000_0600); exp_cre = 1'b1; exp_ready = 1'b0;
    pend_miss = 1'b1;
    tick();
    idle_exp(); exp_sre = 1'b1; exp_ready = 1'b0;
    tick();
    #1;
    rst = 1'b0;
    mdl_hits = 0; mdl_misses = 0;
    sram_ready = 1'b1;
    idle_exp();
    tick();
    rst = 1'b1;
    idle_cycle();

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 9);
      lat = $urandom_range(0, 6);
      if ($urandom_range(0, 3) == 0) a = $urandom & 32'hFFFF_FFFC;
      else a = 32'd1024 + 32'($urandom_range(0, 127)) * 32'd4;
      if (sel < 5) do_load(a, lat, ($urandom_range(0, 9) == 0));
      else if (sel < 8) do_store(a, $urandom, lat, 1'($urandom_range(0, 1)));
      else idle_cycle();
    end
    idle_cycle();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
